// File: rtl/cdc_rx_ctrl_if.sv
// Byte-stream bus between the CDC read side, the receive controller and the downstream parser.
// The master drives the CDC-side inputs and observes the framed stream; the slave is the
// controller.
interface cdc_rx_ctrl_if;
  logic [7:0]  cdcDataIn;
  logic        cdcValidIn;
  logic        cdcErrIn;
  logic        resyncIn;
  logic        cdcRstOut;
  logic [7:0]  dataOut;
  logic        dataValidOut;
  logic        sofOut;
  logic        eofOut;
  logic        badOut;
  logic        lockedOut;
  logic [15:0] frameCntOut;
  logic [15:0] errCntOut;

  modport master (
    output cdcDataIn, cdcValidIn, cdcErrIn, resyncIn,
    input  cdcRstOut, dataOut, dataValidOut, sofOut, eofOut, badOut, lockedOut,
           frameCntOut, errCntOut
  );

  modport slave (
    input  cdcDataIn, cdcValidIn, cdcErrIn, resyncIn,
    output cdcRstOut, dataOut, dataValidOut, sofOut, eofOut, badOut, lockedOut,
           frameCntOut, errCntOut
  );
endinterface

// File: rtl/cdc_rx_ctrl.sv
// Read-domain sequencer for the slow-to-fast byte CDC. Owns the CDC read-side reset, waits
// for a quiet line before joining the stream, then frames the gapless bytes on idle timeouts
// with a one-byte holding register so the last byte can carry eof.
module cdc_rx_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned MAX_LEN      = 1518
) (
  input logic          clkIn,
  input logic          rstIn,
  cdc_rx_ctrl_if.slave bus
);

  localparam logic [1:0] RST_CDC  = 2'd0;
  localparam logic [1:0] QUIET    = 2'd1;
  localparam logic [1:0] IDLE     = 2'd2;
  localparam logic [1:0] IN_FRAME = 2'd3;

  localparam logic [7:0]  GAP_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [1:0]  stateQ, stateD;
  logic [7:0]  rstCntQ, rstCntD;
  logic [7:0]  gapCntQ, gapCntD;
  logic [15:0] lenQ, lenD;
  logic [7:0]  holdQ, holdD;
  logic        sofPendQ, sofPendD;
  logic [15:0] frameCntQ, frameCntD;
  logic [15:0] errCntQ, errCntD;
  logic        cdcRstQ, cdcRstD;
  logic [7:0]  dataQ, dataD;
  logic        dataValidQ, dataValidD;
  logic        sofQ, sofD;
  logic        eofQ, eofD;
  logic        badQ, badD;
  logic        lockedQ, lockedD;
  logic        errInc, frameInc;

  // Next-state, framing and registered-output decode.
  always_comb begin
    stateD     = stateQ;
    rstCntD    = rstCntQ;
    gapCntD    = gapCntQ;
    lenD       = lenQ;
    holdD      = holdQ;
    sofPendD   = sofPendQ;
    dataD      = dataQ;
    dataValidD = 1'b0;
    sofD       = 1'b0;
    eofD       = 1'b0;
    badD       = 1'b0;
    errInc     = 1'b0;
    frameInc   = 1'b0;

    unique case (stateQ)
      RST_CDC: begin
        // Only a resync request is honoured here; it restarts the hold-off.
        if (bus.resyncIn) begin
          rstCntD = '0;
        end else if (rstCntQ == RST_LAST) begin
          stateD  = QUIET;
          gapCntD = '0;
        end else begin
          rstCntD = rstCntQ + 8'd1;
        end
      end

      QUIET: begin
        if (bus.cdcErrIn || bus.resyncIn) begin
          errInc  = bus.cdcErrIn;
          stateD  = RST_CDC;
          rstCntD = '0;
        end else if (bus.cdcValidIn) begin
          // Traffic still running: we may be mid-frame, keep waiting.
          gapCntD = '0;
        end else if (gapCntQ == GAP_LAST) begin
          stateD  = IDLE;
          gapCntD = '0;
        end else begin
          gapCntD = gapCntQ + 8'd1;
        end
      end

      IDLE: begin
        if (bus.cdcErrIn || bus.resyncIn) begin
          errInc  = bus.cdcErrIn;
          stateD  = RST_CDC;
          rstCntD = '0;
        end else if (bus.cdcValidIn) begin
          holdD    = bus.cdcDataIn;
          sofPendD = 1'b1;
          lenD     = 16'd1;
          gapCntD  = '0;
          stateD   = IN_FRAME;
        end
      end

      IN_FRAME: begin
        if (bus.cdcErrIn || bus.resyncIn) begin
          // Abort: flush the held byte as a bad eof; the byte on this cycle is dropped.
          dataValidD = 1'b1;
          dataD      = holdQ;
          sofD       = sofPendQ;
          eofD       = 1'b1;
          badD       = 1'b1;
          errInc     = bus.cdcErrIn;
          stateD     = RST_CDC;
          rstCntD    = '0;
        end else if (bus.cdcValidIn) begin
          dataValidD = 1'b1;
          dataD      = holdQ;
          sofD       = sofPendQ;
          if (lenQ == LEN_MAX) begin
            // Truncate: held byte closes the frame, the overflow byte is dropped and we
            // resynchronise to the next quiet gap.
            eofD    = 1'b1;
            badD    = 1'b1;
            errInc  = 1'b1;
            stateD  = QUIET;
            gapCntD = '0;
          end else begin
            holdD    = bus.cdcDataIn;
            lenD     = lenQ + 16'd1;
            sofPendD = 1'b0;
            gapCntD  = '0;
          end
        end else if (gapCntQ == GAP_LAST) begin
          dataValidD = 1'b1;
          dataD      = holdQ;
          sofD       = sofPendQ;
          eofD       = 1'b1;
          frameInc   = 1'b1;
          stateD     = IDLE;
          gapCntD    = '0;
        end else begin
          gapCntD = gapCntQ + 8'd1;
        end
      end
    endcase

    frameCntD = (frameInc && (frameCntQ != CNT_MAX)) ? frameCntQ + 16'd1 : frameCntQ;
    errCntD   = (errInc && (errCntQ != CNT_MAX)) ? errCntQ + 16'd1 : errCntQ;
    cdcRstD   = (stateD == RST_CDC);
    lockedD   = (stateD == IDLE) || (stateD == IN_FRAME);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      stateQ     <= RST_CDC;
      rstCntQ    <= '0;
      gapCntQ    <= '0;
      lenQ       <= '0;
      holdQ      <= '0;
      sofPendQ   <= 1'b0;
      frameCntQ  <= '0;
      errCntQ    <= '0;
      cdcRstQ    <= 1'b1;
      dataQ      <= '0;
      dataValidQ <= 1'b0;
      sofQ       <= 1'b0;
      eofQ       <= 1'b0;
      badQ       <= 1'b0;
      lockedQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      rstCntQ    <= rstCntD;
      gapCntQ    <= gapCntD;
      lenQ       <= lenD;
      holdQ      <= holdD;
      sofPendQ   <= sofPendD;
      frameCntQ  <= frameCntD;
      errCntQ    <= errCntD;
      cdcRstQ    <= cdcRstD;
      dataQ      <= dataD;
      dataValidQ <= dataValidD;
      sofQ       <= sofD;
      eofQ       <= eofD;
      badQ       <= badD;
      lockedQ    <= lockedD;
    end
  end

  assign bus.cdcRstOut    = cdcRstQ;
  assign bus.dataOut      = dataQ;
  assign bus.dataValidOut = dataValidQ;
  assign bus.sofOut       = sofQ;
  assign bus.eofOut       = eofQ;
  assign bus.badOut       = badQ;
  assign bus.lockedOut    = lockedQ;
  assign bus.frameCntOut  = frameCntQ;
  assign bus.errCntOut    = errCntQ;

endmodule

// File: doc/cdc_rx_ctrl.md
Name: cdc_rx_ctrl

Overview:
Controller in the 250MHz read domain that sequences the slow-to-fast byte CDC. It owns the CDC read-side reset and holds it through start-up and after any CDC error. It waits for a quiet line before accepting data, then frames the gapless byte stream into packets using an idle timeout. Output is a registered byte stream with sof/eof/bad markers, plus saturating frame and error counters, feeding the downstream parser.

Parameters:
IDLE_TIMEOUT, 8, consecutive cycles without cdcValidIn that end a frame; legal range 2..255.
RST_CYCLES, 4, cycles cdcRstOut is held high per resync; legal range 1..255.
MAX_LEN, 1518, maximum bytes per frame before forced truncation; legal range 2..65535.

Ports:
clkIn  in  1  250MHz clock; the only clock.
rstIn  in  1  synchronous, active-high reset.
cdcDataIn  in  8  byte from CDC.
cdcValidIn  in  1  byte valid from CDC.
cdcErrIn  in  1  CDC sequence/tag error.
resyncIn  in  1  single-cycle request to force a CDC resync.
cdcRstOut  out  1  drives the CDC read-side reset.
dataOut  out  8  framed byte.
dataValidOut  out  1  dataOut valid; single-cycle per byte.
sofOut  out  1  first byte of frame; qualified by dataValidOut.
eofOut  out  1  last byte of frame; qualified by dataValidOut.
badOut  out  1  frame aborted or truncated; qualified by eofOut.
lockedOut  out  1  high in IDLE or IN_FRAME.
frameCntOut  out  16  good frames completed; saturates at 0xFFFF.
errCntOut  out  16  cdcErrIn events plus truncations; saturates at 0xFFFF.

Behaviour:
- Clock and reset: single clock clkIn; rstIn is synchronous and active-high.
- Reset values: state=RST_CDC, cdcRstOut=1, all other outputs 0, counters 0, internal counters 0.
- All outputs are registered.
- States: RST_CDC, QUIET, IDLE, IN_FRAME.
- RST_CDC:
  - cdcRstOut=1 for exactly RST_CYCLES cycles (counting from entry), then go to QUIET.
  - Inputs are ignored.
- QUIET:
  - cdcRstOut=0. The gap counter counts cycles with cdcValidIn=0 and clears on any valid.
  - When IDLE_TIMEOUT consecutive idle cycles are seen, go to IDLE. This prevents joining mid-frame.
  - cdcErrIn goes to RST_CDC; errCnt++.
- IDLE:
  - cdcValidIn: capture the byte in the holding register, set sofPend, len=1, go to IN_FRAME.
  - cdcErrIn: errCnt++, go to RST_CDC.
- IN_FRAME, one-byte holding register so eof can mark the last byte:
  - cdcValidIn at cycle t+k (k≤IDLE_TIMEOUT) after the held byte's valid at t: emit the held byte at cycle t+k+1 (sofOut=sofPend, then clear sofPend), capture the new byte, len++.
  - No valid in t+1..t+IDLE_TIMEOUT: emit the held byte at t+IDLE_TIMEOUT+1 with eofOut=1, badOut=0, sofOut=sofPend (a single-byte frame has sof and eof together); frameCnt++; go to IDLE.
  - Valid that would make len exceed MAX_LEN: emit the held byte with eofOut=1, badOut=1; errCnt++; go to QUIET. The overflow byte is dropped.
  - cdcErrIn: emit the held byte next cycle with eofOut=1, badOut=1; errCnt++; go to RST_CDC. The byte on that cycle is discarded.
- Priority on the same cycle: rstIn > cdcErrIn > resyncIn > cdcValidIn.
- resyncIn:
  - In IN_FRAME: same as cdcErrIn but errCnt is not incremented.
  - In QUIET or IDLE: go to RST_CDC.
  - In RST_CDC: restart the RST_CYCLES count.
- rstIn mid-frame: the held byte is discarded; no eof is emitted; downstream must treat rstIn as a frame abort.
- Counters: frameCnt and errCnt saturate and never wrap. len is 16 bits.
- cdcRstOut is never low while state=RST_CDC. dataValidOut is never high outside IN_FRAME exit/emit cycles.

Test Plan:
- Reset release → cdcRstOut=1 for 4 cycles, then QUIET; 8 idle cycles → lockedOut=1 on the following cycle.
- Locked; send bytes 0x11,0x22,0x33 on alternate cycles, then idle → 0x11 with sofOut=1, 0x22 plain, 0x33 with eofOut=1 exactly 9 cycles after its valid; frameCntOut=1, badOut=0.
- Locked; single byte 0xA5 → one beat with sofOut=eofOut=1; gap of 8 cycles between bytes ends the frame; gap of 7 does not.
- Mid-frame cdcErrIn → held byte emitted with eofOut=1, badOut=1; errCntOut+1; cdcRstOut=1 for 4 cycles; lockedOut=0 until 8 quiet cycles.
- MAX_LEN=4, send 6 back-to-back-alternate bytes → 4 bytes emitted, 4th with eof+bad; errCntOut=1; state QUIET; traffic continuing with <8-cycle gaps keeps lockedOut=0.
- Start-up with continuous traffic (valid every 2 cycles) → no output and lockedOut=0 until an 8-cycle gap occurs; force errCnt to 0xFFFF → stays 0xFFFF on further errors.
